// File: rtl/abs_rr_sched.sv
// Round-robin front end for the shared |re + j*im| pipeline: arbitrates N_CH requesters
// with a burst limit, drives the datapath and re-tags each returning magnitude with its channel.
module abs_rr_sched #(
    parameter int N_CH  = 4,
    parameter int LAT   = 3,
    parameter int BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic [N_CH-1:0]             req_val_i,
    input  logic [8*N_CH-1:0]           req_real_i,
    input  logic [8*N_CH-1:0]           req_imag_i,
    output logic [N_CH-1:0]             req_rdy_o,
    output logic                        dp_val_o,
    output logic [7:0]                  dp_real_o,
    output logic [7:0]                  dp_imag_o,
    input  logic                        dp_val_i,
    input  logic [7:0]                  dp_abs_i,
    output logic                        out_val_o,
    output logic [7:0]                  out_abs_o,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] out_ch_o,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BC_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(BURST - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state;
    logic [CH_W-1:0]   own_ch;
    logic [CH_W-1:0]   last;
    logic [BC_W-1:0]   bcnt;

    logic              others_req;
    logic              keep_owner;
    logic              sel_ok;
    logic [CH_W-1:0]   sel_ch;
    logic              grant;
    logic [7:0]        sel_real;
    logic [7:0]        sel_imag;

    logic [CH_W-1:0]   dp_ch;
    logic [LAT-1:0]    tag_v;
    logic [CH_W-1:0]   tag_ch [LAT];

    function automatic logic [CH_W-1:0] wrap_ch(input int v);
        return CH_W'(v % N_CH);
    endfunction

    always_comb begin
        others_req = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (CH_W'(k) != own_ch && req_val_i[k]) others_req = 1'b1;
        end
        keep_owner = (state == OWN) && req_val_i[own_ch] && ((bcnt < BC_MAX) || !others_req);

        sel_ok = 1'b0;
        sel_ch = '0;
        if (keep_owner) begin
            sel_ok = 1'b1;
            sel_ch = own_ch;
        end else begin
            // walk from farthest to nearest so the channel right after last wins
            for (int i = N_CH; i >= 1; i--) begin
                if (req_val_i[wrap_ch(int'(last) + i)]) begin
                    sel_ok = 1'b1;
                    sel_ch = wrap_ch(int'(last) + i);
                end
            end
        end

        sel_real = '0;
        sel_imag = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (CH_W'(k) == sel_ch) begin
                sel_real = req_real_i[8*k +: 8];
                sel_imag = req_imag_i[8*k +: 8];
            end
        end
    end

    // ready is forced low while reset is held so nothing can transfer into a resetting block
    assign grant     = rst_n && en_i && sel_ok;
    assign req_rdy_o = grant ? ({{(N_CH-1){1'b0}}, 1'b1} << sel_ch) : '0;
    assign busy_o    = dp_val_o | (|tag_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            own_ch <= '0;
            last   <= CH_W'(N_CH - 1);
            bcnt   <= '0;
        end else if (grant) begin
            last  <= sel_ch;
            state <= OWN;
            if (state == OWN && sel_ch == own_ch) begin
                if (bcnt != BC_MAX) bcnt <= bcnt + 1'b1;
            end else begin
                own_ch <= sel_ch;
                bcnt   <= '0;
            end
        end else begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_val_o  <= 1'b0;
            dp_real_o <= '0;
            dp_imag_o <= '0;
            dp_ch     <= '0;
        end else begin
            dp_val_o <= grant;
            if (grant) begin
                dp_real_o <= sel_real;
                dp_imag_o <= sel_imag;
                dp_ch     <= sel_ch;
            end
        end
    end

    // tag stage k lines up with the datapath's k+1'th internal cycle; the last one meets dp_val_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int k = 0; k < LAT; k++) tag_ch[k] <= '0;
        end else begin
            tag_v[0]  <= dp_val_o;
            tag_ch[0] <= dp_ch;
            for (int k = 1; k < LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_ch[k] <= tag_ch[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_o <= 1'b0;
            out_abs_o <= '0;
            out_ch_o  <= '0;
            err_o     <= 1'b0;
        end else begin
            out_val_o <= dp_val_i;
            if (dp_val_i) begin
                out_abs_o <= dp_abs_i;
                out_ch_o  <= tag_ch[LAT-1];
            end
            if (dp_val_i != tag_v[LAT-1]) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_abs_rr_sched.sv
// Directed bench for abs_rr_sched with a 3-stage behavioural magnitude datapath attached.
module tb_abs_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic [3:0]  req_val_i;
    logic [31:0] req_real_i;
    logic [31:0] req_imag_i;
    logic [3:0]  req_rdy_o;
    logic        dp_val_o;
    logic [7:0]  dp_real_o;
    logic [7:0]  dp_imag_o;
    logic        dp_val_i;
    logic [7:0]  dp_abs_i;
    logic        out_val_o;
    logic [7:0]  out_abs_o;
    logic [1:0]  out_ch_o;
    logic        busy_o;
    logic        err_o;

    int vecs = 0;
    int errs = 0;

    // ch0 (3,4) ch1 (-6,8) ch2 (5,-12) ch3 (-8,-15)
    logic [7:0] exp_abs [4] = '{8'd5, 8'd10, 8'd13, 8'd17};

    always #5 clk = ~clk;

    abs_rr_sched #(.N_CH(4), .LAT(3), .BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .req_val_i  (req_val_i),
        .req_real_i (req_real_i),
        .req_imag_i (req_imag_i),
        .req_rdy_o  (req_rdy_o),
        .dp_val_o   (dp_val_o),
        .dp_real_o  (dp_real_o),
        .dp_imag_o  (dp_imag_o),
        .dp_val_i   (dp_val_i),
        .dp_abs_i   (dp_abs_i),
        .out_val_o  (out_val_o),
        .out_abs_o  (out_abs_o),
        .out_ch_o   (out_ch_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    // behavioural magnitude datapath, 3 cycles
    function automatic logic [7:0] mag(input logic signed [7:0] re, input logic signed [7:0] im);
        int a, b, s, r;
        a = re;
        b = im;
        s = a * a + b * b;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return 8'(r);
    endfunction

    logic [2:0] p_v;
    logic [7:0] p_abs [3];
    logic       inj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_v <= '0;
            for (int k = 0; k < 3; k++) p_abs[k] <= '0;
        end else begin
            p_v      <= {p_v[1:0], dp_val_o};
            p_abs[0] <= mag(dp_real_o, dp_imag_o);
            p_abs[1] <= p_abs[0];
            p_abs[2] <= p_abs[1];
        end
    end

    assign dp_val_i = p_v[2] | inj;
    assign dp_abs_i = p_abs[2];

    task automatic default_data();
        req_real_i = {8'hF8, 8'h05, 8'hFA, 8'h03};
        req_imag_i = {8'hF1, 8'hF4, 8'h08, 8'h04};
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en_i      = 1'b0;
        req_val_i = '0;
        inj       = 1'b0;
        default_data();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en_i      = 1'b1;
        req_val_i = 4'hF;
        inj       = 1'b0;
        default_data();
        @(negedge clk);
        #1;
        vecs++;
        if (req_rdy_o !== 4'b0000) begin errs++; $display("FAIL reset_rdy got %b want 0000", req_rdy_o); end
        vecs++;
        if ({dp_val_o, dp_real_o, dp_imag_o} !== 17'd0) begin
            errs++; $display("FAIL reset_dp got %b/%h/%h want 0", dp_val_o, dp_real_o, dp_imag_o);
        end
        vecs++;
        if ({out_val_o, out_abs_o, out_ch_o, busy_o, err_o} !== 13'd0) begin
            errs++; $display("FAIL reset_out got val=%b abs=%0d ch=%0d busy=%b err=%b want all 0",
                             out_val_o, out_abs_o, out_ch_o, busy_o, err_o);
        end
        do_reset();
    endtask

    task automatic test_single_sample();
        do_reset();
        req_real_i[23:16] = 8'd3;
        req_imag_i[23:16] = 8'd4;
        for (int i = 0; i < 8; i++) begin
            en_i      = 1'b1;
            req_val_i = (i == 0) ? 4'b0100 : 4'b0000;
            #1;
            vecs++;
            if (req_rdy_o !== ((i == 0) ? 4'b0100 : 4'b0000)) begin
                errs++; $display("FAIL single_rdy cyc %0d got %b", i, req_rdy_o);
            end
            vecs++;
            if (dp_val_o !== (i == 1)) begin errs++; $display("FAIL single_dp_val cyc %0d got %b want %b", i, dp_val_o, i == 1); end
            vecs++;
            if (busy_o !== (i >= 1 && i <= 4)) begin errs++; $display("FAIL single_busy cyc %0d got %b want %b", i, busy_o, i >= 1 && i <= 4); end
            vecs++;
            if (out_val_o !== (i == 5)) begin errs++; $display("FAIL single_out_val cyc %0d got %b want %b", i, out_val_o, i == 5); end
            if (i == 5) begin
                vecs++;
                if ({out_abs_o, out_ch_o} !== {8'd5, 2'd2}) begin
                    errs++; $display("FAIL single_result got abs=%0d ch=%0d want abs=5 ch=2", out_abs_o, out_ch_o);
                end
            end
            @(negedge clk);
        end
        default_data();
    endtask

    task automatic test_full_contention();
        int g;
        int gc;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            en_i      = 1'b1;
            req_val_i = (i < 24) ? 4'hF : 4'h0;
            #1;
            g = (i / 4) % 4;
            vecs++;
            if (req_rdy_o !== ((i < 24) ? (4'b0001 << g) : 4'b0000)) begin
                errs++; $display("FAIL contention_rdy cyc %0d got %b want ch %0d", i, req_rdy_o, g);
            end
            if (i >= 5 && i < 29) begin
                gc = ((i - 5) / 4) % 4;
                vecs++;
                if ({out_val_o, out_ch_o, out_abs_o} !== {1'b1, 2'(gc), exp_abs[gc]}) begin
                    errs++; $display("FAIL contention_out cyc %0d got val=%b ch=%0d abs=%0d want 1/%0d/%0d",
                                     i, out_val_o, out_ch_o, out_abs_o, gc, exp_abs[gc]);
                end
            end else begin
                vecs++;
                if (out_val_o !== 1'b0) begin errs++; $display("FAIL contention_idle_out cyc %0d got %b want 0", i, out_val_o); end
            end
            @(negedge clk);
        end
        #1;
        vecs++;
        if ({busy_o, err_o} !== 2'b00) begin errs++; $display("FAIL contention_drain got busy=%b err=%b want 0 0", busy_o, err_o); end
    endtask

    task automatic test_sparse();
        int exp_g [11] = '{1, 1, 3, 3, 3, 3, 1, 1, 1, 1, 3};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            en_i      = 1'b1;
            req_val_i = (i == 2) ? 4'b1000 : 4'b1010;
            #1;
            vecs++;
            if (req_rdy_o !== (4'b0001 << exp_g[i])) begin
                errs++; $display("FAIL sparse_rdy cyc %0d got %b want ch %0d", i, req_rdy_o, exp_g[i]);
            end
            @(negedge clk);
        end
        req_val_i = '0;
    endtask

    task automatic test_single_requester();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            en_i      = 1'b1;
            req_val_i = 4'b1000;
            #1;
            vecs++;
            if (req_rdy_o !== 4'b1000) begin errs++; $display("FAIL lone_rdy cyc %0d got %b want 1000", i, req_rdy_o); end
            @(negedge clk);
        end
        req_val_i = '0;
    endtask

    task automatic test_enable_drop();
        logic [3:0] er;
        int oc;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            en_i      = !(i >= 6 && i < 12);
            req_val_i = 4'hF;
            #1;
            if (i < 6)       er = (i < 4) ? 4'b0001 : 4'b0010;
            else if (i < 12) er = 4'b0000;
            else             er = 4'b0100;
            vecs++;
            if (req_rdy_o !== er) begin errs++; $display("FAIL endrop_rdy cyc %0d got %b want %b", i, req_rdy_o, er); end
            vecs++;
            if (busy_o !== ((i >= 1 && i <= 9) || i == 13)) begin
                errs++; $display("FAIL endrop_busy cyc %0d got %b", i, busy_o);
            end
            vecs++;
            if (out_val_o !== (i >= 5 && i <= 10)) begin
                errs++; $display("FAIL endrop_out_val cyc %0d got %b", i, out_val_o);
            end
            if (i >= 5 && i <= 10) begin
                oc = (i - 5 < 4) ? 0 : 1;
                vecs++;
                if (out_ch_o !== 2'(oc)) begin errs++; $display("FAIL endrop_out_ch cyc %0d got %0d want %0d", i, out_ch_o, oc); end
            end
            @(negedge clk);
        end
        req_val_i = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            en_i      = 1'b1;
            req_val_i = 4'hF;
            @(negedge clk);
        end
        #1;
        vecs++;
        if ({out_val_o, busy_o, dp_val_o} !== 3'b111) begin
            errs++; $display("FAIL areset_pre got val=%b busy=%b dp=%b want 111", out_val_o, busy_o, dp_val_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({req_rdy_o, dp_val_o, busy_o, out_val_o, out_ch_o, out_abs_o, err_o} !== 19'd0) begin
            errs++; $display("FAIL areset_now got rdy=%b dp=%b busy=%b val=%b ch=%0d abs=%0d err=%b want all 0",
                             req_rdy_o, dp_val_o, busy_o, out_val_o, out_ch_o, out_abs_o, err_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vecs++;
        if (req_rdy_o !== 4'b0001) begin errs++; $display("FAIL areset_first_grant got %b want 0001", req_rdy_o); end
        @(negedge clk);
        req_val_i = '0;
        repeat (6) @(negedge clk);
        #1;
        vecs++;
        if (err_o !== 1'b0) begin errs++; $display("FAIL areset_err got %b want 0", err_o); end
    endtask

    task automatic test_error_inject();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            inj = (i == 0);
            #1;
            vecs++;
            if (err_o !== (i >= 1)) begin errs++; $display("FAIL inject_err cyc %0d got %b want %b", i, err_o, i >= 1); end
            if (i == 1) begin
                vecs++;
                if (out_val_o !== 1'b1) begin errs++; $display("FAIL inject_out_val got %b want 1", out_val_o); end
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (err_o !== 1'b0) begin errs++; $display("FAIL inject_clear got %b want 0", err_o); end
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_sample();
        test_full_contention();
        test_sparse();
        test_single_requester();
        test_enable_drop();
        test_async_reset();
        test_error_inject();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/abs_rr_sched.md
# abs_rr_sched

Round-robin scheduler that shares one magnitude datapath (the 3-cycle |real + j·imag| pipeline) between `N_CH` independent sample requesters. It accepts at most one sample per cycle via per-channel valid/ready handshakes, drives the shared datapath, and tracks the channel ID of every in-flight sample. Each result returns tagged with its source channel. It sits between the per-channel front ends and the downstream magnitude consumers.

## Interface
- `N_CH`, 4: number of requesters, 2..8; `CH_W = max(1, clog2(N_CH))` is a localparam.
- `LAT`, 3: datapath latency in cycles, from `dp_val_o` to `dp_val_i`.
- `BURST`, 4: maximum consecutive grants to one channel while another channel is requesting; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `en_i` in 1: when high, new grants are allowed; when low, in-flight samples still drain.
- `req_val_i` in N_CH: per-channel valid. Must not depend on `req_rdy_o`.
- `req_real_i` in 8·N_CH: channel k uses bits [8k+7:8k]; signed.
- `req_imag_i` in 8·N_CH: same packing as `req_real_i`.
- `req_rdy_o` out N_CH: one-hot or zero, combinational; a transfer occurs when valid & ready.
- `dp_val_o`, `dp_real_o[7:0]`, `dp_imag_o[7:0]` out: registered drive to the datapath.
- `dp_val_i` in 1, `dp_abs_i` in 8: datapath return.
- `out_val_o` out 1, `out_abs_o` out 8, `out_ch_o` out CH_W: registered tagged result.
- `busy_o` out 1: any sample in flight, including the one in the `dp_*` register.
- `err_o` out 1: sticky tag/valid mismatch flag.

## Operation
- **Arbiter FSM**, two states:
  - IDLE: no owner.
  - OWN: owner `own_ch`, with burst count `bcnt`.
- **Selection each cycle, only when `en_i` = 1:**
  - In OWN, if `req_val_i[own_ch]` = 1 and either `bcnt < BURST-1` or no other channel is requesting, select `own_ch`.
  - Otherwise, select the first requesting channel searching upward (with wrap) from `last+1`, where `last` is the last granted channel.
  - No channel requesting, or `en_i` = 0: nothing is selected.
- `req_rdy_o[sel]` = 1 only for the selected channel.
- **On a transfer from channel c:**
  - `last` ← c.
  - If c == `own_ch` in OWN, `bcnt` ← `bcnt` + 1 (saturating); otherwise `own_ch` ← c and `bcnt` ← 0.
  - State ← OWN.
- **Return to IDLE:** on a cycle with no transfer, or when the owner's valid is low.
- **Datapath drive:** on transfer, `dp_real_o`/`dp_imag_o` ← channel-c data, `dp_val_o` ← 1, `tag_pipe[0]` ← {1, c}. With no transfer, `dp_val_o` ← 0 and the data registers hold.
- **Tag pipe:** a shift register of LAT entries {v, ch}, shifting every cycle and aligned so its last entry coincides with `dp_val_i`.
- **Result:** `out_val_o` ← `dp_val_i`, `out_abs_o` ← `dp_abs_i` when `dp_val_i` = 1 (holds otherwise), `out_ch_o` ← tag ch.
- **Error:** `err_o` sets if `dp_val_i` ≠ tag v at the pipe end, and clears only on reset. The result is still emitted using `dp_val_i`.
- **`busy_o`:** OR of `dp_val_o` and all tag v bits.
- **No backpressure:** the output has no ready; the consumer must accept every `out_val_o`.

## Timing
- **Reset values:** all outputs are 0 (`req_rdy_o` is 0 while `rst_n` = 0). State IDLE, `last` = N_CH-1 (so ch0 has first priority), `bcnt` = 0, tag pipe cleared.
- **Latency:** a transfer in cycle t gives `dp_val_o` in t+1, `dp_val_i` in t+1+LAT, and `out_val_o` in t+2+LAT (t+5 with the defaults).
- **Throughput:** one sample per cycle, in any channel mix.
- **Order:** output order equals acceptance order.
- **`en_i` falling:** no transfer in that same cycle. Samples already in flight emerge on schedule, and `busy_o` falls the cycle after the last tag leaves.
- **`en_i` rising:** arbitration resumes from the saved `last`; burst ownership is lost (IDLE).
- **Reset mid-stream:** in-flight tags are discarded. Any later stray `dp_val_i` sets `err_o`, which is acceptable and documented.
- **Single requester:** granted every cycle indefinitely; the BURST limit applies only under contention.

## Test plan
- **Single sample:** ch2 presents (3,4) in cycle 10; shared datapath instantiated -> `req_rdy_o` = 4'b0100 in cycle 10, `dp_val_o` in 11, `out_val_o` = 1 / `out_abs_o` = 5 / `out_ch_o` = 2 in cycle 15, `busy_o` high 11..14.
- **Full contention:** all 4 channels valid continuously, BURST = 4 -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., no bubbles. Outputs carry the same channel sequence delayed 5 cycles.
- **Sparse requesters:** ch1 and ch3 valid, ch1's valid drops after 2 grants -> grants 1,1,3,3,3,3,1...; fairness holds when `last` wraps from 3 to 0.
- **Enable drop:** `en_i` low for 6 cycles during full contention -> no `req_rdy_o` during those cycles, the 5 in-flight results still appear, `busy_o` falls, and the resumed grant continues from `last`+1.
- **Async reset:** assert `rst_n` low mid-burst at a non-edge time -> all outputs 0 immediately; after release ch0 is granted first.
- **Error injection:** force `dp_val_i` = 1 with an empty tag pipe -> `err_o` = 1 the next cycle, staying high until reset.
